// File: rtl/mem_arbiter.sv
// Arbiter that shares one unified word memory between icache 4-beat block fills and dcache word accesses.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the dcache has fixed priority.
module mem_arbiter #(
   parameter int DATA_BASE = 256
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         INST_MEM_READ,
   input  logic [5:0]   INST_MEM_ADDRESS,
   output logic [127:0] INST_MEM_READDATA,
   output logic         INST_MEM_BUSYWAIT,
   input  logic         MEM_READ,
   input  logic         MEM_WRITE,
   input  logic [5:0]   MEM_ADDRESS,
   input  logic [31:0]  MEM_WRITEDATA,
   output logic [31:0]  MEM_READDATA,
   output logic         MEM_BUSYWAIT,
   output logic         UMEM_READ,
   output logic         UMEM_WRITE,
   output logic [8:0]   UMEM_ADDRESS,
   output logic [31:0]  UMEM_WRITEDATA,
   input  logic [31:0]  UMEM_READDATA,
   input  logic         UMEM_BUSYWAIT
);

   typedef enum logic [2:0] {IDLE, D_ACC, D_DONE, I_BEAT, I_GAP, I_DONE} state_t;

   state_t      state;
   logic [1:0]  beat;
   logic [5:0]  inst_block;
   logic        data_req;
   logic        grant_data;
   logic        grant_inst;
   logic [8:0]  data_word_addr;
`ifdef ARB_ROUND_ROBIN_EN
   logic        lru;
`endif

   assign data_req       = MEM_READ | MEM_WRITE;
   assign data_word_addr = 9'(DATA_BASE) + {3'b000, MEM_ADDRESS};

`ifdef ARB_ROUND_ROBIN_EN
   // lru=0 favours the dcache when both caches are waiting in IDLE
   assign grant_data = data_req & (!INST_MEM_READ | !lru);
`else
   assign grant_data = data_req;
`endif
   assign grant_inst = INST_MEM_READ & !grant_data;

   assign MEM_BUSYWAIT      = data_req & (state != D_DONE);
   assign INST_MEM_BUSYWAIT = INST_MEM_READ & (state != I_DONE);

   // The UMEM request lines are registered here, so the memory only ever sees glitch-free requests
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state             <= IDLE;
         beat              <= 2'd0;
         inst_block        <= 6'd0;
         UMEM_READ         <= 1'b0;
         UMEM_WRITE        <= 1'b0;
         UMEM_ADDRESS      <= 9'd0;
         UMEM_WRITEDATA    <= 32'd0;
         MEM_READDATA      <= 32'd0;
         INST_MEM_READDATA <= 128'd0;
`ifdef ARB_ROUND_ROBIN_EN
         lru               <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant_data) begin
                  state          <= D_ACC;
                  beat           <= 2'd0;
                  UMEM_READ      <= MEM_READ;
                  UMEM_WRITE     <= MEM_WRITE & !MEM_READ;
                  UMEM_ADDRESS   <= data_word_addr;
                  UMEM_WRITEDATA <= MEM_WRITEDATA;
               end else if (grant_inst) begin
                  state        <= I_BEAT;
                  beat         <= 2'd0;
                  inst_block   <= INST_MEM_ADDRESS;
                  UMEM_READ    <= 1'b1;
                  UMEM_WRITE   <= 1'b0;
                  UMEM_ADDRESS <= {1'b0, INST_MEM_ADDRESS, 2'b00};
               end
            end
            D_ACC: begin
               if (!UMEM_BUSYWAIT) begin
                  if (UMEM_READ) begin
                     MEM_READDATA <= UMEM_READDATA;
                  end
                  UMEM_READ  <= 1'b0;
                  UMEM_WRITE <= 1'b0;
                  state      <= D_DONE;
`ifdef ARB_ROUND_ROBIN_EN
                  lru        <= 1'b1;
`endif
               end
            end
            D_DONE: begin
               state <= IDLE;
            end
            I_BEAT: begin
               if (!UMEM_BUSYWAIT) begin
                  INST_MEM_READDATA[{beat, 5'b00000} +: 32] <= UMEM_READDATA;
                  UMEM_READ <= 1'b0;
                  if (beat == 2'd3) begin
                     state <= I_DONE;
`ifdef ARB_ROUND_ROBIN_EN
                     lru   <= 1'b0;
`endif
                  end else begin
                     state <= I_GAP;
                     beat  <= beat + 2'd1;
                  end
               end
            end
            I_GAP: begin
               // one idle cycle lets the memory see a fresh request edge for the next word
               state        <= I_BEAT;
               UMEM_READ    <= 1'b1;
               UMEM_ADDRESS <= {1'b0, inst_block, beat};
            end
            I_DONE: begin
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               UMEM_READ  <= 1'b0;
               UMEM_WRITE <= 1'b0;
            end
         endcase
      end
   end

endmodule
